dice_roll_controller: RTL



---
 rtl/dice_ctrl_pkg.sv | 22 ++
 rtl/button_debounce.sv | 48 ++++
 rtl/dice_roll_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dice_ctrl_pkg.sv
// Shared types and helpers for the dice roll controller.
//   state_t   : controller FSM states
//   face_t    : 3-bit face value driven to the eight_dice decoder
//   FACE_MIN  : lowest face value
//   face_next : advance a face value, wrapping from fmax back to FACE_MIN
package dice_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    SHOW
  } state_t;

  typedef logic [2:0] face_t;

  localparam face_t FACE_MIN = 3'd1;

  function automatic face_t face_next(input face_t f, input face_t fmax);
    return (f >= fmax) ? FACE_MIN : face_t'(f + 3'd1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus debounce counter for the roll button.
//   clk, rst : clock, asynchronous active-high reset
//   btn_i    : raw asynchronous button, active-high
//   level_o  : synchronized button level
//   press_o  : one-cycle pulse once the level has been high for DEBOUNCE_CYCLES cycles;
//              re-armed only after the level returns to 0
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
      // Counter saturates at CNT_MAX, so CNT_LAST is crossed only once per high level.
      if (!r_sync2) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_press <= r_sync2 && (r_cnt == CNT_LAST);
    end
  end

  assign level_o = r_sync2;
  assign press_o = r_press;

endmodule

// File: rtl/dice_roll_controller.sv
// Dice display sequencer: debounced roll button, decelerating roll animation, held final face.
//   clk, rst    : clock, asynchronous active-high reset
//   btn_i       : raw roll button, active-high
//   face_o      : current face 1..FACE_MAX (eight_dice decoder select)
//   rolling_o   : high while the animation runs
//   done_o      : one-cycle pulse on entry to SHOW
//   scan_tick_o : one-cycle enable every SCAN_DIV cycles for the row/column scanner
// Optional build macro DICE_HOLD_ROLL_EN: while the button stays held after the press the face
// spins at the fastest step rate; deceleration starts when the synchronized level falls.
module dice_roll_controller
  import dice_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned STEP_BASE       = 1000000,
  parameter int unsigned NUM_STEPS       = 12,
  parameter int unsigned FACE_MAX        = 6,
  parameter int unsigned SCAN_DIV        = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_i,
  output logic [2:0] face_o,
  output logic       rolling_o,
  output logic       done_o,
  output logic       scan_tick_o
);

  localparam int unsigned KW = $clog2(NUM_STEPS + 1);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [KW-1:0] K_LAST      = KW'(NUM_STEPS - 1);
  localparam logic [SW-1:0] SCAN_LAST   = SW'(SCAN_DIV - 1);
  localparam face_t         FMAX        = face_t'(FACE_MAX);
  localparam logic [31:0]   STEP_BASE_W = 32'(STEP_BASE);

  logic w_level;
  logic w_press;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_i),
    .level_o(w_level),
    .press_o(w_press)
  );

  state_t        r_state, w_state_next;
  face_t         r_face, w_face_next;
  face_t         r_seed;
  logic [31:0]   r_timer, w_timer_next;
  logic [KW-1:0] r_k, w_k_next;
  logic          r_done, w_done_next;
  logic [SW-1:0] r_scan;

  logic [31:0]   w_timer_eff;
  logic [31:0]   w_limit;
  logic          w_step_end;
  logic          w_hold_phase;

`ifdef DICE_HOLD_ROLL_EN
  logic r_hold, w_hold_next;

  // Falling level restarts the step timer so the first decelerating step starts that cycle.
  assign w_hold_phase = r_hold && w_level;
  assign w_timer_eff  = (r_hold && !w_level) ? 32'd0 : r_timer;
`else
  assign w_hold_phase = 1'b0;
  assign w_timer_eff  = r_timer;
`endif

  // Step k lasts STEP_BASE*(k+1) cycles; k stays 0 during a hold phase.
  assign w_limit    = STEP_BASE_W * (32'(r_k) + 32'd1);
  assign w_step_end = (w_timer_eff == w_limit - 32'd1);

  always_comb begin
    w_state_next = r_state;
    w_face_next  = r_face;
    w_timer_next = r_timer;
    w_k_next     = r_k;
    w_done_next  = 1'b0;
`ifdef DICE_HOLD_ROLL_EN
    w_hold_next  = r_hold;
`endif
    unique case (r_state)
      IDLE, SHOW: begin
        if (w_press) begin
          w_state_next = ROLL;
          w_face_next  = r_seed;
          w_timer_next = 32'd0;
          w_k_next     = '0;
`ifdef DICE_HOLD_ROLL_EN
          w_hold_next  = 1'b1;
`endif
        end
      end
      ROLL: begin
`ifdef DICE_HOLD_ROLL_EN
        w_hold_next = w_hold_phase;
`endif
        if (w_step_end) begin
          w_face_next  = face_next(r_face, FMAX);
          w_timer_next = 32'd0;
          if (!w_hold_phase) begin
            if (r_k == K_LAST) begin
              w_state_next = SHOW;
              w_done_next  = 1'b1;
            end else begin
              w_k_next = r_k + KW'(1);
            end
          end
        end else begin
          w_timer_next = w_timer_eff + 32'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_face  <= FACE_MIN;
      r_timer <= 32'd0;
      r_k     <= '0;
      r_done  <= 1'b0;
`ifdef DICE_HOLD_ROLL_EN
      r_hold  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_face  <= w_face_next;
      r_timer <= w_timer_next;
      r_k     <= w_k_next;
      r_done  <= w_done_next;
`ifdef DICE_HOLD_ROLL_EN
      r_hold  <= w_hold_next;
`endif
    end
  end

  // Free-running seed and scan divider, independent of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seed <= FACE_MIN;
      r_scan <= '0;
    end else begin
      r_seed <= face_next(r_seed, FMAX);
      r_scan <= (r_scan == SCAN_LAST) ? '0 : r_scan + SW'(1);
    end
  end

  assign face_o      = r_face;
  assign rolling_o   = (r_state == ROLL);
  assign done_o      = r_done;
  assign scan_tick_o = (r_scan == SCAN_LAST);

endmodule
